// File: rtl/counter_ng_if.sv
// counter_ng_if: control/status bundle between the driving side and counter_ng.
// The master modport drives the counter controls; the slave modport is the counter itself.
// wrap_cnt is present regardless of COUNTER_WRAP_CNT_EN so the signal list never changes.
interface counter_ng_if #(
    parameter int WIDTH      = 4,
    parameter int WRAP_CNT_W = 8
);
    logic                  load_n;
    logic                  up_down;
    logic                  ce;
    logic [WIDTH-1:0]      data_load;
    logic [WIDTH-1:0]      step;
    logic [WIDTH-1:0]      limit;
    logic                  sat_mode;
    logic                  clr_flags;
    logic [WIDTH-1:0]      count_out;
    logic                  max_count;
    logic                  zero;
    logic                  tc;
    logic                  ovf_sticky;
    logic [WRAP_CNT_W-1:0] wrap_cnt;

    modport master (
        output load_n, up_down, ce, data_load, step, limit, sat_mode, clr_flags,
        input  count_out, max_count, zero, tc, ovf_sticky, wrap_cnt
    );

    modport slave (
        input  load_n, up_down, ce, data_load, step, limit, sat_mode, clr_flags,
        output count_out, max_count, zero, tc, ovf_sticky, wrap_cnt
    );
endinterface

// File: rtl/counter_ng.sv
// counter_ng: parametrised up/down counter with programmable step and inclusive
// upper limit, wrap or saturate at the bounds, registered terminal-count pulse
// and sticky overflow flag.
// Optional feature: define COUNTER_WRAP_CNT_EN to build the wrap event counter;
// without it wrap_cnt is tied to zero.
module counter_ng #(
    parameter int WIDTH      = 4,
    parameter int WRAP_CNT_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    counter_ng_if.slave   bus
);
    localparam int W1 = WIDTH + 1;

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_ovf;

    logic [W1-1:0]    w_c;
    logic [W1-1:0]    w_s;
    logic [W1-1:0]    w_lim;
    logic [W1-1:0]    w_len;
    logic [W1-1:0]    w_sum;
    logic [W1-1:0]    w_dn;
    logic [W1-1:0]    w_under;
    logic [W1-1:0]    w_up_wrap;
    logic [W1-1:0]    w_under_rem;
    logic [W1-1:0]    w_dn_wrap;
    logic [WIDTH-1:0] w_next;
    logic             w_event;
    logic             w_wrap_ev;

    // Arithmetic is done one bit wider so sums and the range length limit+1 never overflow.
    assign w_c   = {1'b0, r_count};
    assign w_s   = {1'b0, bus.step};
    assign w_lim = {1'b0, bus.limit};
    assign w_len = w_lim + W1'(1);
    assign w_sum = w_c + w_s;
    assign w_dn  = w_c - w_s;
    assign w_under = w_s - w_c;

    // Wrap results taken modulo the range length; the step may exceed the range many times.
    // Downward: (c - s) mod L computed from the positive deficit s - c.
    assign w_up_wrap   = w_sum % w_len;
    assign w_under_rem = w_under % w_len;
    assign w_dn_wrap   = (w_under_rem == '0) ? '0 : (w_len - w_under_rem);

    assign w_wrap_ev = w_event & ~bus.sat_mode;

    // Next count and boundary event: load beats count enable; an out-of-range count
    // (limit lowered at runtime) is pulled back before any stepping.
    always_comb begin
        w_next  = r_count;
        w_event = 1'b0;
        if (!bus.load_n) begin
            w_next = (bus.data_load > bus.limit) ? bus.limit : bus.data_load;
        end else if (bus.ce) begin
            if (w_c > w_lim) begin
                w_event = 1'b1;
                w_next  = bus.sat_mode ? bus.limit : '0;
            end else if (bus.up_down) begin
                if (w_sum > w_lim) begin
                    w_event = 1'b1;
                    w_next  = bus.sat_mode ? bus.limit : w_up_wrap[WIDTH-1:0];
                end else begin
                    w_next  = w_sum[WIDTH-1:0];
                end
            end else begin
                if (w_s > w_c) begin
                    w_event = 1'b1;
                    w_next  = bus.sat_mode ? '0 : w_dn_wrap[WIDTH-1:0];
                end else begin
                    w_next  = w_dn[WIDTH-1:0];
                end
            end
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

    // Terminal-count pulse aligned with the updated count; sticky flag where a
    // coincident event outranks the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tc  <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            r_tc <= w_event;
            if (w_event) begin
                r_ovf <= 1'b1;
            end else if (bus.clr_flags) begin
                r_ovf <= 1'b0;
            end
        end
    end

`ifdef COUNTER_WRAP_CNT_EN
    logic [WRAP_CNT_W-1:0] r_wrap_cnt;

    // Wrap-mode boundary events only; clear-with-event restarts the count at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrap_cnt <= '0;
        end else if (bus.clr_flags) begin
            r_wrap_cnt <= w_wrap_ev ? WRAP_CNT_W'(1) : '0;
        end else if (w_wrap_ev) begin
            r_wrap_cnt <= r_wrap_cnt + WRAP_CNT_W'(1);
        end
    end

    assign bus.wrap_cnt = r_wrap_cnt;
`else
    logic w_unused_wrap_ev;
    assign w_unused_wrap_ev = w_wrap_ev;
    assign bus.wrap_cnt     = '0;
`endif

    assign bus.count_out  = r_count;
    assign bus.tc         = r_tc;
    assign bus.ovf_sticky = r_ovf;
    assign bus.max_count  = (r_count == bus.limit);
    assign bus.zero       = (r_count == '0);
endmodule

// File: tb/tb_counter_ng.sv
// tb_counter_ng: table-driven check of counter_ng (WIDTH=4) with a scoreboard queue,
// plus hand-written sequences for async reset and the wrap event counter.
module tb_counter_ng;
    localparam int WIDTH      = 4;
    localparam int WRAP_CNT_W = 8;

`ifdef COUNTER_WRAP_CNT_EN
    localparam int WC_AFTER_12 = 3;
    localparam int WC_AFTER_CLR_EV = 1;
`else
    localparam int WC_AFTER_12 = 0;
    localparam int WC_AFTER_CLR_EV = 0;
`endif

    typedef struct {
        logic       load_n;
        logic       up_down;
        logic       ce;
        logic [3:0] data_load;
        logic [3:0] step;
        logic [3:0] limit;
        logic       sat_mode;
        logic       clr_flags;
        logic [3:0] e_count;
        logic       e_max;
        logic       e_zero;
        logic       e_tc;
        logic       e_ovf;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    vec_t sb[$];
    vec_t tbl[$];

    counter_ng_if #(.WIDTH(WIDTH), .WRAP_CNT_W(WRAP_CNT_W)) bus ();

    counter_ng #(.WIDTH(WIDTH), .WRAP_CNT_W(WRAP_CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(input logic ld_n, input logic ud, input logic ce,
                                input int dl, input int st, input int lim,
                                input logic sat, input logic clr,
                                input int ec, input logic em, input logic ez,
                                input logic et, input logic eo);
        vec_t v;
        v.load_n = ld_n; v.up_down = ud; v.ce = ce;
        v.data_load = 4'(dl); v.step = 4'(st); v.limit = 4'(lim);
        v.sat_mode = sat; v.clr_flags = clr;
        v.e_count = 4'(ec); v.e_max = em; v.e_zero = ez; v.e_tc = et; v.e_ovf = eo;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    // Drive one vector at the negedge, queue its expectation, compare after the next edge.
    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        bus.load_n = v.load_n; bus.up_down = v.up_down; bus.ce = v.ce;
        bus.data_load = v.data_load; bus.step = v.step; bus.limit = v.limit;
        bus.sat_mode = v.sat_mode; bus.clr_flags = v.clr_flags;
        sb.push_back(v);
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        check("count_out",  idx, int'(bus.count_out),  int'(e.e_count));
        check("max_count",  idx, int'(bus.max_count),  int'(e.e_max));
        check("zero",       idx, int'(bus.zero),       int'(e.e_zero));
        check("tc",         idx, int'(bus.tc),         int'(e.e_tc));
        check("ovf_sticky", idx, int'(bus.ovf_sticky), int'(e.e_ovf));
    endtask

    task automatic idle_inputs();
        bus.load_n = 1'b1; bus.up_down = 1'b1; bus.ce = 1'b0;
        bus.data_load = '0; bus.step = '0; bus.limit = 4'd15;
        bus.sat_mode = 1'b0; bus.clr_flags = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        idle_inputs();

        //            ld ud ce dl st lim sat clr | cnt max zero tc ovf
        tbl.push_back(mk(0, 1, 0,  8, 0, 9, 0, 0,   8, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1,  0, 3, 9, 0, 0,   1, 0, 0, 1, 1));
        tbl.push_back(mk(1, 1, 0,  0, 3, 9, 0, 0,   1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 1,  0, 3, 9, 0, 0,   4, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 0,  0, 0, 9, 0, 1,   4, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1,  0, 5, 9, 0, 0,   9, 1, 0, 1, 1));
        tbl.push_back(mk(1, 1, 1,  0, 1, 9, 0, 1,   0, 0, 1, 1, 1));
        tbl.push_back(mk(1, 1, 0,  0, 0, 9, 0, 1,   0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0,  2, 0,15, 1, 0,   2, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1,  0, 4,15, 1, 0,   0, 0, 1, 1, 1));
        tbl.push_back(mk(1, 0, 1,  0, 4,15, 1, 0,   0, 0, 1, 1, 1));
        tbl.push_back(mk(1, 0, 0,  0, 0,15, 1, 1,   0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 12, 0, 9, 0, 0,   9, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1,  3, 5, 9, 0, 0,   3, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1,  0, 0, 9, 0, 0,   3, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1,  0,15, 9, 1, 0,   9, 1, 0, 1, 1));
        tbl.push_back(mk(1, 1, 1,  0,15, 9, 1, 0,   9, 1, 0, 1, 1));
        tbl.push_back(mk(1, 1, 1,  0, 0, 5, 1, 0,   5, 1, 0, 1, 1));
        tbl.push_back(mk(1, 1, 1,  0, 0, 2, 0, 0,   0, 0, 1, 1, 1));
        tbl.push_back(mk(1, 1, 1,  0, 1, 0, 0, 0,   0, 1, 1, 1, 1));
        tbl.push_back(mk(1, 0, 1,  0,15, 3, 0, 0,   1, 0, 0, 1, 1));
        tbl.push_back(mk(1, 1, 1,  0,14, 3, 0, 0,   3, 1, 0, 1, 1));
        tbl.push_back(mk(0, 1, 0,  0, 0, 3, 0, 0,   0, 0, 1, 0, 1));

        repeat (2) @(negedge clk);
        check("rst_count", 0, int'(bus.count_out), 0);
        check("rst_tc",    0, int'(bus.tc), 0);
        check("rst_ovf",   0, int'(bus.ovf_sticky), 0);
        check("rst_wrap",  0, int'(bus.wrap_cnt), 0);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        // Asynchronous reset between edges clears state without waiting for a clock.
        apply(mk(0, 1, 0, 7, 0, 9, 0, 0,   7, 0, 0, 0, 1), 100);
        apply(mk(1, 1, 1, 0, 5, 9, 0, 0,   2, 0, 0, 1, 1), 101);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_count", 102, int'(bus.count_out), 0);
        check("async_rst_tc",    102, int'(bus.tc), 0);
        check("async_rst_ovf",   102, int'(bus.ovf_sticky), 0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Wrap event counter: limit 3, step 1, wrap mode, 12 ups from 0.
        for (int i = 0; i < 15; i++) begin
            int c;
            c = (i + 1) % 4;
            apply(mk(1, 1, 1, 0, 1, 3, 0, 0, c, c == 3, c == 0, c == 0, i >= 3), 200 + i);
            if (i == 11) check("wrap_cnt_12", 211, int'(bus.wrap_cnt), WC_AFTER_12);
        end
        apply(mk(1, 1, 1, 0, 1, 3, 0, 1,   0, 0, 1, 1, 1), 215);
        check("wrap_cnt_clr_ev", 215, int'(bus.wrap_cnt), WC_AFTER_CLR_EV);
        apply(mk(1, 1, 1, 0, 1, 0, 1, 0,   0, 1, 1, 1, 1), 216);
        check("wrap_cnt_sat", 216, int'(bus.wrap_cnt), WC_AFTER_CLR_EV);
        apply(mk(1, 1, 0, 0, 0, 3, 0, 1,   0, 0, 1, 0, 0), 217);
        check("wrap_cnt_clr", 217, int'(bus.wrap_cnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
